// File: rtl/rca_pkg.sv
// Shared definitions for the serial word adder built around the 4-bit ripple-carry slice.
package rca_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands share a sign and the result sign differs from it.
    function automatic logic ovf_term(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder: a chain of four full adders.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_serial_word_adder.sv
// Multi-cycle WIDTH-bit adder: streams one nibble per cycle, LSB first, through a
// single 4-bit ripple-carry slice, then holds the word result on a valid/ready output.
module rca_serial_word_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state, state_nxt;
    logic               idle_rdy;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
    logic               cout_reg, ovf_reg;
    logic               last;

    logic [NIBBLE_W-1:0] add_a, add_b, add_s;
    logic                add_co;

    assign add_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign add_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign last  = (idx == IDX_W'(NIBBLES - 1));

    ripple_carry_adder_4bit u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The unused encoding behaves exactly like IDLE.
    always_comb begin
        state_nxt = state;
        idle_rdy  = 1'b0;
        out_valid = 1'b0;
        case (state)
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                idle_rdy = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
        endcase
    end

    assign in_ready = idle_rdy & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (idle_rdy && in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == BUSY) begin
            sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= add_s;
            carry <= add_co;
            // The top nibble of the sum is still combinational here, so take its MSB from the slice.
            if (last) begin
                cout_reg <= add_co;
                ovf_reg  <= ovf_term(a_reg[WIDTH-1], b_reg[WIDTH-1], add_s[NIBBLE_W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_rca_serial_word_adder.sv
// Randomised and directed bench for rca_serial_word_adder against an arithmetic reference.
module tb_rca_serial_word_adder;

    localparam int W = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    rca_serial_word_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {overflow, cout, sum}, from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint u;
        longint s;
        logic   ov;
        u  = longint'(x) + longint'(y) + longint'(c);
        s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
        return {ov, u[W], u[W-1:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand set, wait for the result and compare it plus the latency.
    task automatic do_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic release_out);
        int          wait_cyc;
        int          lat;
        logic [W+1:0] exp;
        exp = model(x, y, c);
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom(); b = $urandom(); cin = $urandom();
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_val({tag, "_lat"}, lat, NIB);
        check_val({tag, "_sum"}, sum, exp[W-1:0]);
        check_val({tag, "_cout"}, cout, exp[W]);
        check_val({tag, "_ovf"}, overflow, exp[W+1]);
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_val({tag, "_ovalid_drop"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        logic [W-1:0] hs;
        logic         hc;
        int           seen;
        int           cyc, n_acc, n_res, last_acc;
        logic         acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2;
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_sum", sum, '0);
        check_val("rst_cout", cout, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_in_ready", in_ready, 1'b1);

        do_add("small",  16'h0001, 16'h0002, 1'b0, 1'b1);
        do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        do_add("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        do_add("negovf", 16'h8000, 16'h8000, 1'b0, 1'b1);

        // Stall the consumer and offer new operands that must be refused.
        do_add("hold", 16'h0FFF, 16'h0000, 1'b1, 1'b0);
        hs = sum; hc = cout;
        a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("hold_sum", sum, 16'h1000);
            check_val("hold_cout", {cout, hc}, 2'b00);
            check_val("hold_in_ready", in_ready, 1'b0);
            check_val("hold_out_valid", out_valid, 1'b1);
        end
        check_val("hold_sum_stable", sum, hs);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check_val("hold_release_valid", out_valid, 1'b0);
        check_val("hold_release_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_val("hold_no_accept", seen, 0);

        // Abort an addition during its third nibble cycle.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_val("abort_in_ready_back", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_val("abort_no_stale", seen, 0);
        do_add("after_abort", 16'h1234, 16'h4321, 1'b0, 1'b1);

        // Back-to-back random traffic with both handshakes tied high.
        a = $urandom(); b = $urandom(); cin = $urandom();
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; n_acc = 0; n_res = 0; last_acc = -1;
        while (n_res < 3 && cyc < 200) begin
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, cin));
                if (last_acc >= 0) check_val("b2b_gap", cyc - last_acc, NIB + 2);
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_val("b2b_sum", sum, e[W-1:0]);
                    check_val("b2b_cout", cout, e[W]);
                    check_val("b2b_ovf", overflow, e[W+1]);
                end else begin
                    check_val("b2b_unexpected", out_valid, 1'b0);
                end
                n_res++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (n_acc < 3) begin
                    a = $urandom(); b = $urandom(); cin = $urandom();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check_val("b2b_results", n_res, 3);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
